// File: rtl/spike_rx_ni.sv
// spike_rx_ni -- ejection-side network interface for one mesh node.
//
// Single-flit spike packets from the router's local output port are accepted
// with a valid/ready handshake and buffered in a FIFO. The node CPU drains the
// FIFO through a memory-mapped port that uses the data-memory busywait
// handshake (one wait cycle per access).
//
// Register map (mem_address[3:2]):
//   0 POP    : head flit, removed from the FIFO (0 when empty)
//   1 STATUS : [7:0] count, [15:8] drop count, [16] empty, [17] full
//   2 PEEK   : head flit, left in place (0 when empty)
//   3 CLEAR  : write zeroes the drop count, read returns 0
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_data    flit from router: [31:24] dest, [23:16] src, [15:0] neuron
//   in_ready            NI can take a flit this cycle (FIFO not full)
//   mem_read/mem_write  CPU request, held until mem_busywait drops
//   mem_address         byte address, [3:2] selects the register
//   mem_writedata       unused; a write is only a strobe
//   mem_readdata        registered read data
//   mem_busywait        CPU must stall
//   spike_pending       registered FIFO-non-empty flag
//
// Build option: define SPIKE_RX_DEST_CHECK_EN to discard flits whose
// destination differs from NODE_ID and count them in the drop counter.
// Without it every accepted flit is stored and the drop count stays 0.

module spike_rx_ni #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int NODE_ID    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [3:0]            mem_address,
  input  logic [DATA_WIDTH-1:0] mem_writedata,
  output logic [DATA_WIDTH-1:0] mem_readdata,
  output logic                  mem_busywait,
  output logic                  spike_pending
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, ACK} state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]           count_reg, count_next;
  logic [7:0]              drop_cnt;
  logic [DATA_WIDTH-1:0]   readdata_reg;
  logic                    pending_reg;

  logic        empty, full, push, store, pop, access, rd_access, wr_access, clear_hit;
  logic [1:0]  sel;
  logic [DATA_WIDTH-1:0] head, read_mux;

  assign sel       = mem_address[3:2];
  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CW'(FIFO_DEPTH));
  // Ready depends only on the registered count, so a pop in the same cycle
  // does not open a slot until the next cycle.
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;

  assign access    = (state_reg == IDLE) && (mem_read || mem_write);
  assign rd_access = access && mem_read;               // read wins over write
  assign wr_access = access && !mem_read && mem_write;
  assign clear_hit = wr_access && (sel == 2'd3);
  assign pop       = rd_access && (sel == 2'd0) && !empty;
  assign head      = fifo_mem[rd_ptr_reg];

`ifdef SPIKE_RX_DEST_CHECK_EN
  logic dest_ok;
  logic [7:0] drop_cnt_reg;

  assign dest_ok  = (in_data[31:24] == 8'(NODE_ID));
  assign store    = push && dest_ok;
  assign drop_cnt = drop_cnt_reg;

  // CLEAR has priority over a drop on the same edge; the counter sticks at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt_reg <= 8'd0;
    else if (clear_hit)
      drop_cnt_reg <= 8'd0;
    else if (push && !dest_ok && (drop_cnt_reg != 8'hFF))
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, mem_writedata, mem_address[1:0]};
`else
  assign store    = push;
  assign drop_cnt = 8'd0;

  logic unused_ok;
  assign unused_ok = &{1'b0, mem_writedata, mem_address[1:0], clear_hit, 8'(NODE_ID)};
`endif

  // Storage array has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (store)
      fifo_mem[wr_ptr_reg] <= in_data;
  end

  always_comb begin
    count_next = count_reg;
    case ({store, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    read_mux = '0;
    case (sel)
      2'd0, 2'd2: read_mux = empty ? '0 : head;
      2'd1:       read_mux = {14'd0, full, empty, drop_cnt, 8'(count_reg)};
      default:    read_mux = '0;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    mem_busywait = 1'b0;
    case (state_reg)
      IDLE: begin
        mem_busywait = mem_read || mem_write;
        if (mem_read || mem_write)
          state_next = ACK;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      readdata_reg <= '0;
      pending_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      pending_reg <= !empty;
      if (store)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (rd_access)
        readdata_reg <= read_mux;
    end
  end

  assign mem_readdata  = readdata_reg;
  assign spike_pending = pending_reg;

endmodule

// File: tb/tb_spike_rx_ni.sv
// Self-checking bench for spike_rx_ni (FIFO_DEPTH=8, NODE_ID=0).
// Pushed flits go to a scoreboard queue; POP/PEEK results are compared
// against its head, STATUS against a small count/drop model.

module tb_spike_rx_ni;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_address = '0;
  logic [31:0] mem_writedata = '0;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
  logic        spike_pending;

  always #5 clk = ~clk;

  spike_rx_ni #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .NODE_ID(0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait),
    .spike_pending (spike_pending)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          mcount = 0;
  int          mdrop = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {14'd0, (mcount == DEPTH), (mcount == 0), 8'(mdrop), 8'(mcount)};
  endfunction

  function automatic bit is_mine(input logic [31:0] flit);
`ifdef SPIKE_RX_DEST_CHECK_EN
    return flit[31:24] == 8'd0;
`else
    return (flit == flit);
`endif
  endfunction

  // One-cycle flit offer; the model decides whether it is accepted/stored.
  task automatic push(input logic [31:0] flit);
    bit acc;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = flit;
    acc = (mcount != DEPTH);
    check("in_ready", 32'(in_ready), 32'(acc));
    if (acc) begin
      if (is_mine(flit)) begin
        exp_q.push_back(flit);
        mcount++;
      end else if (mdrop < 255) begin
        mdrop++;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    $display("push %h offered, accept expected %0d", flit, acc);
  endtask

  task automatic cpu_access(input bit is_read, input logic [1:0] sel, output logic [31:0] data);
    int waited;
    @(negedge clk);
    mem_read    = is_read;
    mem_write   = !is_read;
    mem_address = {sel, 2'b00};
    #1 check("busy_req", 32'(mem_busywait), 32'd1);
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (mem_busywait && waited < 4);
    check("latency", 32'(waited), 32'd1);
    data      = mem_readdata;
    mem_read  = 1'b0;
    mem_write = 1'b0;
`ifdef SPIKE_RX_DEST_CHECK_EN
    if (!is_read && sel == 2'd3) mdrop = 0;
`endif
    @(posedge clk);  // ACK -> IDLE
    $display("cpu %s reg %0d data %h", is_read ? "rd" : "wr", sel, data);
  endtask

  task automatic pop_chk(input string tag);
    logic [31:0] d, e;
    cpu_access(1'b1, 2'd0, d);
    e = '0;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      mcount--;
    end
    check(tag, d, e);
  endtask

  task automatic peek_chk(input string tag);
    logic [31:0] d, e;
    cpu_access(1'b1, 2'd2, d);
    e = (exp_q.size() != 0) ? exp_q[0] : 32'd0;
    check(tag, d, e);
  endtask

  task automatic status_chk(input string tag);
    logic [31:0] d;
    cpu_access(1'b1, 2'd1, d);
    check(tag, d, exp_status());
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, r;

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_pending", 32'(spike_pending), 32'd0);
    check("rst_busy", 32'(mem_busywait), 32'd0);
    check("rst_rdata", mem_readdata, 32'd0);
    cpu_access(1'b1, 2'd1, d);
    check("status_reset", d, 32'h0001_0000);

    // Basic ordering and spike_pending timing.
    push(32'h0001_0005);
    @(negedge clk);
    check("pending_E", 32'(spike_pending), 32'd0);
    @(negedge clk);
    check("pending_E1", 32'(spike_pending), 32'd1);
    push(32'h0002_0007);
    peek_chk("peek");
    pop_chk("pop1");
    pop_chk("pop2");
    status_chk("status_empty");

    // Empty pop.
    pop_chk("pop_empty");
    peek_chk("peek_empty");
    status_chk("status_empty2");

    // Fill, then a refused offer.
    for (int i = 0; i < DEPTH; i++) push({8'h00, 8'h10, 16'(i)});
    push(32'h0000_BEEF);
    status_chk("status_full");
    check("status_full_const", exp_status(), 32'h0002_0008);

    // Ninth flit held while a POP completes: accepted one cycle later.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h0009_0009;
    mem_read = 1'b1;
    mem_address = 4'h0;
    #1;
    check("full_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    check("pop_on_full", mem_readdata, exp_q.pop_front());
    mcount--;
    check("ready_after_pop", 32'(in_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back(32'h0009_0009);
    mcount++;
    #1 in_valid = 1'b0;
    check("refull_ready", 32'(in_ready), 32'd0);
    status_chk("status_refull");
    for (int i = 0; i < DEPTH; i++) pop_chk("drain");
    status_chk("status_drained");

    // Wrap-around.
    for (int i = 0; i < 20; i++) begin
      r = $urandom;
      push({8'h00, r[23:0]});
      pop_chk("wrap");
    end
    status_chk("status_wrap");

    // Destination filtering / drop counter.
    push(32'h0300_0001);
    status_chk("status_foreign");
    cpu_access(1'b0, 2'd3, d);
    status_chk("status_cleared");
`ifdef SPIKE_RX_DEST_CHECK_EN
    for (int i = 0; i < 300; i++) push(32'h0300_0000 | 32'(i));
    status_chk("status_saturated");
    check("drop_sat", exp_status() & 32'h0000_FF00, 32'h0000_FF00);
`else
    pop_chk("pop_foreign");
`endif

    // Reset in the middle of a POP with three entries.
    push(32'h0000_0011);
    push(32'h0000_0022);
    push(32'h0000_0033);
    @(negedge clk);
    mem_read = 1'b1;
    mem_address = 4'h0;
    #1 check("busy_mid", 32'(mem_busywait), 32'd1);
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mem_read = 1'b0;
    rst_n = 1'b1;
    exp_q.delete();
    mcount = 0;
    mdrop = 0;
    #1;
    check("rst2_busy", 32'(mem_busywait), 32'd0);
    check("rst2_rdata", mem_readdata, 32'd0);
    check("rst2_pending", 32'(spike_pending), 32'd0);
    check("rst2_ready", 32'(in_ready), 32'd1);
    status_chk("status_after_rst");
    pop_chk("pop_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spike_rx_ni.md
# spike_rx_ni

Ejection-side network interface for one mesh node. Accepts single-flit spike packets from the router's local output port with a valid/ready handshake and buffers them in a FIFO. The node CPU drains them through a memory-mapped read port that uses the same busywait handshake as the node data memory. It is the receiving end of the spike traffic that node CPUs inject into the mesh.

## Interface
- `DATA_WIDTH`, 32: flit and CPU data width; fixed at 32.
- `FIFO_DEPTH`, 8: buffer entries; power of two, 2..128.
- `NODE_ID`, 0: this node's id, compared against flit bits [31:24].
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: router presents a flit.
- `in_data` in 32: flit; [31:24] dest node, [23:16] src node, [15:0] src neuron.
- `in_ready` out 1: NI accepts a flit this cycle.
- `mem_read` in 1: CPU read request; held until busywait drops.
- `mem_write` in 1: CPU write request; held until busywait drops.
- `mem_address` in 4: byte address; [3:2] selects register, [1:0] ignored.
- `mem_writedata` in 32: write data (ignored, write is a strobe).
- `mem_readdata` out 32: registered read data.
- `mem_busywait` out 1: CPU must stall.
- `spike_pending` out 1: FIFO non-empty, registered.

## Operation
- Register map, by [3:2]:
  - 0 POP: return head flit and remove it.
  - 1 STATUS: [7:0] count, [15:8] drop count, [16] empty, [17] full, rest 0.
  - 2 PEEK: return head flit without removing it.
  - 3 CLEAR: a write zeroes the drop count; a read returns 0.
- Push occurs when `in_valid && in_ready`. `in_ready = (count != FIFO_DEPTH)`, driven combinationally from registered count.
- POP or PEEK on an empty FIFO returns 0x00000000. Pointers and count are unchanged.
- Full FIFO: `in_ready`=0 even if a POP completes in the same cycle. The router retries the next cycle.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits and is zero-extended into STATUS[7:0].
- Access FSM states:
  - IDLE: on `mem_read|mem_write` go to ACK. At that edge, capture readdata, perform pop/clear.
  - ACK: go to IDLE unconditionally.
  - Reads take priority over writes if both are asserted. The action is a read.
- `mem_busywait = (mem_read|mem_write) && state==IDLE`.

## Timing
- Reset values: `mem_readdata`=0, `mem_busywait`=0 (with no request), `spike_pending`=0, count=0, drop count=0, FSM=IDLE, `in_ready`=1.
- Ingress: a flit accepted at edge E is visible in STATUS and PEEK for a read captured at E+1 or later. `spike_pending` rises after edge E+1.
- CPU access latency: one wait cycle.
  - Request in cycle N: busywait=1 during N; data, pop and clear are applied at the end of N.
  - Cycle N+1: busywait=0 and readdata is valid.
  - A back-to-back request can start in N+2.
- A POP captured at edge E and a STATUS captured at E+2 show count decremented by 1.
- Reset asserted mid-access: the FSM returns to IDLE immediately, the FIFO is emptied, and no partial pop survives.
- Drop count saturates at 255. A drop and a CLEAR in the same edge: CLEAR wins, result 0.

## Configuration
- `SPIKE_RX_DEST_CHECK_EN` defined:
  - A handshaken flit with [31:24] != NODE_ID is consumed (`in_ready` still governs the handshake) but not stored, and the drop count is incremented.
- Undefined:
  - Every accepted flit is stored and the drop count reads 0 permanently. CLEAR is a no-op.

## Test plan
- Reset then idle: `in_ready`=1, `spike_pending`=0; STATUS read returns 0x00010000 after exactly one busywait cycle.
- Push flits 0x00010005, 0x00020007 (NODE_ID=0). Then PEEK returns 0x00010005, POP returns 0x00010005, POP returns 0x00020007, STATUS returns 0x00010000.
- Push 8 flits with DEPTH=8: `in_ready`=0 and STATUS=0x00020008. Hold `in_valid` with a ninth flit while popping once: the ninth flit is accepted on the cycle after the pop, and the final count is 8.
- Pop an empty FIFO: returns 0x00000000 and count stays 0. Wrap-around: 20 push/pop pairs return data in order.
- With `SPIKE_RX_DEST_CHECK_EN`, push 0x03000001 (dest 3):
  - not stored; STATUS=0x00010100;
  - write CLEAR, then STATUS=0x00010000;
  - 300 mismatches saturate the drop field at 0xFF.
- Assert `rst_n` low mid-POP with 3 entries: after release, count=0, `mem_busywait`=0, `mem_readdata`=0.
